seven_seg_decoder: RTL and testbench
====================================

Name: seven_seg_decoder

Overview:
Registered hex/BCD-to-seven-segment decoder for one display digit. It takes a 4-bit value plus blank, lamp-test and decimal-point controls, and drives the a–g segment lines and the DP line one clock later. It sits between a digit-select or multiplexing stage and the display pins. Output polarity is selectable for common-cathode or common-anode parts.

Parameters:
ACTIVE_LOW, 0, 0 = segment lit when bit is 1 (common cathode); 1 = all outputs (seg, dp) inverted (common anode).
HEX_EN, 1, 1 = inputs 10–15 decode to A,b,C,d,E,F; 0 = inputs 10–15 show a single dash (segment g only).

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
en  input  1  update enable; when 0, all registered outputs hold
in  input  4  digit value 0–15
blank  input  1  1 = all segments and DP off
lamp_test  input  1  1 = all segments and DP on
dp_in  input  1  requested decimal-point state (1 = lit)
seg  output  7  segment drive, seg[0]=a, seg[1]=b … seg[6]=g
dp  output  1  decimal-point drive
valid  output  1  1 when registered digit is BCD (0–9) and display is not blanked or in lamp test

Behaviour:
- Reset and clocking: one clock domain. Reset is synchronous and active-low. When rst_n=0 at a rising clk edge, the outputs go to the off state: seg = all off (7'h00 if ACTIVE_LOW=0, 7'h7F if ACTIVE_LOW=1), dp off, valid=0. Reset overrides en.
- Latency: exactly 1 cycle. Outputs reflect inputs sampled at the previous rising edge where en=1. No combinational path from inputs to outputs.
- Update: when en=0 (and not in reset), seg, dp and valid hold their values.
- Priority, highest first:
  - lamp_test=1: all 7 segments lit, dp lit, valid=0.
  - blank=1: all segments off, dp off, valid=0.
  - Otherwise: normal decode, dp = dp_in, valid = (in <= 9).
- Decode table (active-high form, bit order g..a):
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F
  - 4 = 66, 5 = 6D, 6 = 7D, 7 = 07
  - 8 = 7F, 9 = 6F
  - With HEX_EN=1: A = 77, b = 7C, C = 39, d = 5E, E = 79, F = 71.
  - With HEX_EN=0, inputs 10–15 = 40 (dash).
- Polarity: ACTIVE_LOW=1 inverts the final seg and dp bits only. It does not change priority, timing or valid.
- valid is independent of HEX_EN. Inputs 10–15 always give valid=0.
- Inputs are assumed synchronous to clk. No internal synchronizers.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in=8 and lamp_test=1 -> seg=00, dp=0, valid=0. Release reset with en=1, in=8, lamp_test=0 -> next cycle seg=7F, valid=1.
- Sweep: en=1, blank=0, lamp_test=0, dp_in=0; step in 0..15, one per cycle -> one cycle after each value, seg matches the decode table (3F, 06, 5B … 71). valid=1 for 0–9 and 0 for 10–15. Repeat with HEX_EN=0 -> 10–15 give 40.
- Priority: in=3, dp_in=0, blank=1, lamp_test=1 -> seg=7F, dp=1, valid=0. Drop lamp_test -> seg=00, dp=0. Drop blank -> seg=4F, dp=0, valid=1.
- Hold: in=5 with en=1 -> seg=6D. Set en=0 and change in to 2 for 3 cycles -> seg stays 6D. Set en=1 -> seg=5B next cycle.
- Polarity: ACTIVE_LOW=1, in=0, dp_in=1 -> seg=40, dp=0, valid=1. During reset -> seg=7F, dp=1.
- Latency: toggle in between 1 and 7 every cycle -> seg alternates 06 and 07, lagging the input by exactly one clock with no glitch cycles.

Source files
------------

// File: rtl/seven_seg_decoder.sv
// Registered hex/BCD to seven-segment decoder for one display digit.
// Latency 1 cycle; en=0 holds outputs (no backpressure, no handshake).
module seven_seg_decoder #(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter bit HEX_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] in,
  input  logic       blank,
  input  logic       lamp_test,
  input  logic       dp_in,
  output logic [6:0] seg,
  output logic       dp,
  output logic       valid
);

  localparam logic [6:0] SEG_ALL  = 7'h7F;
  localparam logic [6:0] SEG_NONE = 7'h00;
  localparam logic [6:0] SEG_DASH = 7'h40;

  // Output-pin values meaning "everything dark" for the chosen polarity.
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = ACTIVE_LOW;

  logic [6:0] glyph;
  logic [6:0] seg_hi;
  logic       dp_hi;
  logic       valid_nxt;

  always_comb begin
    glyph = SEG_DASH;
    case (in)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = HEX_EN ? 7'h77 : SEG_DASH;
      4'hB: glyph = HEX_EN ? 7'h7C : SEG_DASH;
      4'hC: glyph = HEX_EN ? 7'h39 : SEG_DASH;
      4'hD: glyph = HEX_EN ? 7'h5E : SEG_DASH;
      4'hE: glyph = HEX_EN ? 7'h79 : SEG_DASH;
      4'hF: glyph = HEX_EN ? 7'h71 : SEG_DASH;
      default: glyph = SEG_DASH;
    endcase
  end

  // Lamp test beats blank, blank beats normal decode; all in active-high form.
  always_comb begin
    seg_hi    = glyph;
    dp_hi     = dp_in;
    valid_nxt = (in <= 4'd9);
    if (lamp_test) begin
      seg_hi    = SEG_ALL;
      dp_hi     = 1'b1;
      valid_nxt = 1'b0;
    end else if (blank) begin
      seg_hi    = SEG_NONE;
      dp_hi     = 1'b0;
      valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg   <= SEG_OFF;
      dp    <= DP_OFF;
      valid <= 1'b0;
    end else if (en) begin
      seg   <= seg_hi ^ {7{ACTIVE_LOW}};
      dp    <= dp_hi ^ ACTIVE_LOW;
      valid <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_seven_seg_decoder.sv
// Directed bench: three decoder instances (default, HEX_EN=0, ACTIVE_LOW=1) share one stimulus.
module tb_seven_seg_decoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] in;
  logic       blank;
  logic       lamp_test;
  logic       dp_in;

  logic [6:0] seg_h, seg_d, seg_l;
  logic       dp_h, dp_d, dp_l;
  logic       valid_h, valid_d, valid_l;

  int passed = 0;
  int total  = 0;

  logic [6:0] hex_tab  [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [6:0] dash_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  seven_seg_decoder #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b1)) dut_hex (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in), .blank(blank),
    .lamp_test(lamp_test), .dp_in(dp_in), .seg(seg_h), .dp(dp_h), .valid(valid_h)
  );

  seven_seg_decoder #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b0)) dut_dash (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in), .blank(blank),
    .lamp_test(lamp_test), .dp_in(dp_in), .seg(seg_d), .dp(dp_d), .valid(valid_d)
  );

  seven_seg_decoder #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b1)) dut_low (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in), .blank(blank),
    .lamp_test(lamp_test), .dp_in(dp_in), .seg(seg_l), .dp(dp_l), .valid(valid_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; in = 4'd8; lamp_test = 1'b1; blank = 1'b0; dp_in = 1'b0;
    tick();
    tick();
    total++;
    if ({seg_h, dp_h, valid_h} !== {7'h00, 1'b0, 1'b0})
      $display("FAIL reset_hex: got seg=%h dp=%b valid=%b, want seg=00 dp=0 valid=0", seg_h, dp_h, valid_h);
    else passed++;
    total++;
    if ({seg_l, dp_l, valid_l} !== {7'h7F, 1'b1, 1'b0})
      $display("FAIL reset_low: got seg=%h dp=%b valid=%b, want seg=7f dp=1 valid=0", seg_l, dp_l, valid_l);
    else passed++;
    rst_n = 1'b1; lamp_test = 1'b0;
    tick();
    total++;
    if ({seg_h, valid_h} !== {7'h7F, 1'b1})
      $display("FAIL reset_release: got seg=%h valid=%b, want seg=7f valid=1", seg_h, valid_h);
    else passed++;
  endtask

  task automatic test_sweep();
    logic [6:0] exp_h, exp_d;
    logic       exp_v;
    en = 1'b1; blank = 1'b0; lamp_test = 1'b0; dp_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in = 4'(i);
      tick();
      exp_h = hex_tab[i];
      exp_d = dash_tab[i];
      exp_v = (i <= 9);
      total++;
      if ({seg_h, dp_h, valid_h} !== {exp_h, 1'b0, exp_v})
        $display("FAIL sweep_hex in=%0d: got seg=%h dp=%b valid=%b, want seg=%h dp=0 valid=%b",
                 i, seg_h, dp_h, valid_h, exp_h, exp_v);
      else passed++;
      total++;
      if ({seg_d, valid_d} !== {exp_d, exp_v})
        $display("FAIL sweep_dash in=%0d: got seg=%h valid=%b, want seg=%h valid=%b",
                 i, seg_d, valid_d, exp_d, exp_v);
      else passed++;
    end
  endtask

  task automatic test_priority();
    in = 4'd3; dp_in = 1'b0; blank = 1'b1; lamp_test = 1'b1;
    tick();
    total++;
    if ({seg_h, dp_h, valid_h} !== {7'h7F, 1'b1, 1'b0})
      $display("FAIL prio_lamp: got seg=%h dp=%b valid=%b, want seg=7f dp=1 valid=0", seg_h, dp_h, valid_h);
    else passed++;
    total++;
    if ({seg_l, dp_l} !== {7'h00, 1'b0})
      $display("FAIL prio_lamp_low: got seg=%h dp=%b, want seg=00 dp=0", seg_l, dp_l);
    else passed++;
    lamp_test = 1'b0;
    tick();
    total++;
    if ({seg_h, dp_h, valid_h} !== {7'h00, 1'b0, 1'b0})
      $display("FAIL prio_blank: got seg=%h dp=%b valid=%b, want seg=00 dp=0 valid=0", seg_h, dp_h, valid_h);
    else passed++;
    dp_in = 1'b1;
    tick();
    total++;
    if (dp_h !== 1'b0)
      $display("FAIL prio_blank_dp: got dp=%b, want dp=0", dp_h);
    else passed++;
    blank = 1'b0; dp_in = 1'b0;
    tick();
    total++;
    if ({seg_h, dp_h, valid_h} !== {7'h4F, 1'b0, 1'b1})
      $display("FAIL prio_normal: got seg=%h dp=%b valid=%b, want seg=4f dp=0 valid=1", seg_h, dp_h, valid_h);
    else passed++;
  endtask

  task automatic test_hold();
    en = 1'b1; in = 4'd5;
    tick();
    total++;
    if (seg_h !== 7'h6D)
      $display("FAIL hold_load: got seg=%h, want seg=6d", seg_h);
    else passed++;
    en = 1'b0; in = 4'd2; lamp_test = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if ({seg_h, valid_h} !== {7'h6D, 1'b1})
        $display("FAIL hold_cycle%0d: got seg=%h valid=%b, want seg=6d valid=1", c, seg_h, valid_h);
      else passed++;
    end
    lamp_test = 1'b0; en = 1'b1;
    tick();
    total++;
    if (seg_h !== 7'h5B)
      $display("FAIL hold_release: got seg=%h, want seg=5b", seg_h);
    else passed++;
  endtask

  task automatic test_polarity();
    en = 1'b1; in = 4'd0; dp_in = 1'b1; blank = 1'b0; lamp_test = 1'b0;
    tick();
    total++;
    if ({seg_l, dp_l, valid_l} !== {7'h40, 1'b0, 1'b1})
      $display("FAIL pol_low: got seg=%h dp=%b valid=%b, want seg=40 dp=0 valid=1", seg_l, dp_l, valid_l);
    else passed++;
    total++;
    if ({seg_h, dp_h} !== {7'h3F, 1'b1})
      $display("FAIL pol_high: got seg=%h dp=%b, want seg=3f dp=1", seg_h, dp_h);
    else passed++;
    in = 4'hA;
    tick();
    total++;
    if ({seg_l, valid_l} !== {7'h08, 1'b0})
      $display("FAIL pol_low_hex: got seg=%h valid=%b, want seg=08 valid=0", seg_l, valid_l);
    else passed++;
    rst_n = 1'b0;
    tick();
    total++;
    if ({seg_l, dp_l, valid_l} !== {7'h7F, 1'b1, 1'b0})
      $display("FAIL pol_reset: got seg=%h dp=%b valid=%b, want seg=7f dp=1 valid=0", seg_l, dp_l, valid_l);
    else passed++;
    rst_n = 1'b1; dp_in = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [6:0] prev_seg;
    en = 1'b1; in = 4'd7;
    tick();
    prev_seg = 7'h07;
    for (int c = 0; c < 8; c++) begin
      in = (c % 2 == 0) ? 4'd1 : 4'd7;
      #2;
      total++;
      if (seg_h !== prev_seg)
        $display("FAIL latency_comb cyc%0d: got seg=%h before edge, want seg=%h", c, seg_h, prev_seg);
      else passed++;
      tick();
      prev_seg = (c % 2 == 0) ? 7'h06 : 7'h07;
      total++;
      if (seg_h !== prev_seg)
        $display("FAIL latency_edge cyc%0d: got seg=%h, want seg=%h", c, seg_h, prev_seg);
      else passed++;
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; in = 4'd0; blank = 1'b0; lamp_test = 1'b0; dp_in = 1'b0;
    test_reset();
    test_sweep();
    test_priority();
    test_hold();
    test_polarity();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
